cam_srl_tcam: RTL

Ternary, self-allocating successor to the shift-register CAM: each entry stores a per-slice wildcard and a valid bit, and an insert command picks the lowest free entry itself. Searches run in a registered single-cycle pipeline with a per-slice search enable. Table maintenance goes through a command/response handshake. It sits beside the SIMD dispatch logic as the tag/operand lookup table, replacing the address-driven CAM where software-free allocation and don't-care matching are needed.

---
 rtl/cam_srl_tcam.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/cam_srl_tcam.sv
// Ternary CAM built from per-slice shift-register lookup tables with self-allocating insert.
// Searches are registered; inserts and deletes rewrite one row over 2**SLICE_WIDTH shifts.
module cam_srl_tcam #(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 5,
  parameter int SLICE_WIDTH = 4,
  localparam int RAM_DEPTH   = 2**ADDR_WIDTH,
  localparam int SLICE_COUNT = (DATA_WIDTH + SLICE_WIDTH - 1) / SLICE_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_op,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_data,
  input  logic [SLICE_COUNT-1:0]  cmd_wildcard,
  output logic                    resp_valid,
  output logic [ADDR_WIDTH-1:0]   resp_addr,
  output logic                    resp_error,
  input  logic                    search_valid,
  input  logic [DATA_WIDTH-1:0]   search_data,
  input  logic [SLICE_COUNT-1:0]  search_slice_en,
  output logic                    result_valid,
  output logic                    result_match,
  output logic [ADDR_WIDTH-1:0]   result_addr,
  output logic [RAM_DEPTH-1:0]    result_many,
  output logic [ADDR_WIDTH:0]     occupancy,
  output logic                    full
);
  localparam int SRL_DEPTH = 2**SLICE_WIDTH;
  localparam int PAD_WIDTH = SLICE_COUNT * SLICE_WIDTH;

  // state  | meaning
  // INIT   | clear every row, commands blocked
  // IDLE   | accept commands
  // INSERT | shift key/wildcard pattern into target row
  // DELETE | shift zeros into target row
  typedef enum logic [1:0] {INIT, IDLE, INSERT, DELETE} state_t;

  state_t state, state_next;
  logic [SLICE_WIDTH-1:0] cnt, cnt_next;
  logic [ADDR_WIDTH-1:0]  target, free_addr, hit_addr, resp_addr_next;
  logic [PAD_WIDTH-1:0]   key_q, cmd_pad, search_pad;
  logic [SLICE_COUNT-1:0] wc_q, shift_bits;
  logic [RAM_DEPTH-1:0]   valid, valid_next, hit;
  logic [ADDR_WIDTH:0]    occ_next;
  logic shift_all, shift_row, latch_cmd, set_valid, clr_valid, resp_next, resp_err_next;
  logic [SLICE_COUNT-1:0][SRL_DEPTH-1:0] srl [RAM_DEPTH];

  assign cmd_pad    = PAD_WIDTH'(cmd_data);
  assign search_pad = PAD_WIDTH'(search_data);
  assign cmd_ready  = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      cnt   <= '1;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    shift_all      = 1'b0;
    shift_row      = 1'b0;
    shift_bits     = '0;
    latch_cmd      = 1'b0;
    set_valid      = 1'b0;
    clr_valid      = 1'b0;
    resp_next      = 1'b0;
    resp_err_next  = 1'b0;
    resp_addr_next = resp_addr;
    case (state)
      INIT: begin
        shift_all = 1'b1;
        cnt_next  = cnt - 1'b1;
        if (cnt == '0) state_next = IDLE;
      end
      IDLE: begin
        if (cmd_valid) begin
          if (!cmd_op && (&valid)) begin
            resp_next      = 1'b1;
            resp_err_next  = 1'b1;
            resp_addr_next = '0;
          end else if (cmd_op && !valid[cmd_addr]) begin
            resp_next      = 1'b1;
            resp_err_next  = 1'b1;
            resp_addr_next = cmd_addr;
          end else begin
            latch_cmd  = 1'b1;
            clr_valid  = cmd_op;
            cnt_next   = '1;
            state_next = cmd_op ? DELETE : INSERT;
          end
        end
      end
      INSERT, DELETE: begin
        shift_row = 1'b1;
        if (state == INSERT)
          for (int i = 0; i < SLICE_COUNT; i++)
            shift_bits[i] = wc_q[i] | (key_q[i*SLICE_WIDTH +: SLICE_WIDTH] == cnt);
        cnt_next = cnt - 1'b1;
        if (cnt == '0) begin
          state_next     = IDLE;
          set_valid      = (state == INSERT);
          resp_next      = 1'b1;
          resp_addr_next = target;
        end
      end
      default: state_next = INIT;
    endcase
  end

  always_comb begin
    free_addr = '0;
    for (int e = RAM_DEPTH-1; e >= 0; e--)
      if (!valid[e]) free_addr = ADDR_WIDTH'(e);
  end

  always_comb begin
    valid_next = valid;
    if (clr_valid) valid_next[cmd_addr] = 1'b0;
    if (set_valid) valid_next[target]   = 1'b1;
    occ_next = '0;
    for (int e = 0; e < RAM_DEPTH; e++)
      occ_next = occ_next + (ADDR_WIDTH+1)'(valid_next[e]);
  end

  // A row that is being shifted this cycle holds a partial pattern and must not hit.
  always_comb begin
    for (int e = 0; e < RAM_DEPTH; e++) begin
      hit[e] = valid[e] && !(shift_all || (shift_row && target == ADDR_WIDTH'(e)));
      for (int i = 0; i < SLICE_COUNT; i++)
        if (search_slice_en[i] && !srl[e][i][search_pad[i*SLICE_WIDTH +: SLICE_WIDTH]])
          hit[e] = 1'b0;
    end
    hit_addr = '0;
    for (int e = RAM_DEPTH-1; e >= 0; e--)
      if (hit[e]) hit_addr = ADDR_WIDTH'(e);
  end

  always_ff @(posedge clk) begin
    for (int e = 0; e < RAM_DEPTH; e++)
      if (shift_all || (shift_row && target == ADDR_WIDTH'(e)))
        for (int i = 0; i < SLICE_COUNT; i++)
          srl[e][i] <= {srl[e][i][SRL_DEPTH-2:0], shift_bits[i]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid        <= '0;
      occupancy    <= '0;
      full         <= 1'b0;
      target       <= '0;
      key_q        <= '0;
      wc_q         <= '0;
      resp_valid   <= 1'b0;
      resp_error   <= 1'b0;
      resp_addr    <= '0;
      result_valid <= 1'b0;
      result_match <= 1'b0;
      result_addr  <= '0;
      result_many  <= '0;
    end else begin
      valid      <= valid_next;
      occupancy  <= occ_next;
      full       <= (occ_next == (ADDR_WIDTH+1)'(RAM_DEPTH));
      resp_valid <= resp_next;
      resp_error <= resp_err_next;
      resp_addr  <= resp_addr_next;
      if (latch_cmd) begin
        target <= cmd_op ? cmd_addr : free_addr;
        key_q  <= cmd_pad;
        wc_q   <= cmd_wildcard;
      end
      result_valid <= search_valid;
      result_match <= search_valid && (|hit);
      result_addr  <= search_valid ? hit_addr : '0;
      result_many  <= search_valid ? hit : '0;
    end
  end
endmodule
